// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce, edge, long-press and auto-repeat per channel, merged into one valid/ready event stream
// Ports:
//   i_clock, i_reset_n                   clock, synchronous active-low reset
//   i_in[CHANNELS]                       raw asynchronous button lines
//   o_level/o_press/o_release[CHANNELS]  debounced state (1 = pressed) and one-cycle edge pulses
//   o_event_valid/_chan/_type            presented event (type 0 press, 1 release, 2 long, 3 repeat)
//   i_event_ready                        consumer accepts the presented event
//   o_overflow[CHANNELS]                 sticky: an event was dropped on this channel
module button_conditioner #(
    parameter int CHANNELS = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [CHANNELS-1:0] i_in,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic                o_event_valid,
    output logic [CW-1:0]       o_event_chan,
    output logic [1:0]          o_event_type,
    input  logic                i_event_ready,
    output logic [CHANNELS-1:0] o_overflow
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW = $clog2(HMAX + 1);
    localparam int REP_M1 = REPEAT_CYCLES > 0 ? REPEAT_CYCLES - 1 : 0;

    logic [CHANNELS-1:0] r_sync1, r_sync2, r_level, r_press, r_release, r_long, r_slot_v, r_overflow;
    logic [DW-1:0]       r_deb [CHANNELS];
    logic [HW-1:0]       r_hold [CHANNELS];
    logic [1:0]          r_slot_t [CHANNELS];
    logic                r_event_valid;
    logic [CW-1:0]       r_event_chan;
    logic [1:0]          r_event_type;

    logic [CHANNELS-1:0] w_norm, w_flip, w_hit, w_ev, w_drain;
    logic [1:0]          w_ev_t [CHANNELS];
    logic                w_take, w_any;
    logic [CW-1:0]       w_pick;
    logic [1:0]          w_pick_t;

    assign w_norm = ACTIVE_LOW != 0 ? ~i_in : i_in;
    assign w_ev = w_flip | w_hit;
    assign w_take = !r_event_valid || i_event_ready;

    always_comb begin
        w_flip = '0;
        w_hit = '0;
        w_drain = '0;
        w_ev_t = '{default: '0};
        w_any = 1'b0;
        w_pick = '0;
        w_pick_t = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // the cycle whose increment would reach DEBOUNCE_CYCLES is the flip cycle
            w_flip[i] = (r_sync2[i] != r_level[i]) && (r_deb[i] == DW'(DEBOUNCE_CYCLES - 1));
            // hold events never coincide with a release edge
            w_hit[i] = r_level[i] && !w_flip[i] &&
                       (r_long[i] ? (REPEAT_CYCLES > 0) && (r_hold[i] == HW'(REP_M1))
                                  : (r_hold[i] == HW'(LONG_CYCLES - 1)));
            w_ev_t[i] = w_flip[i] ? {1'b0, r_level[i]} : {1'b1, r_long[i]};
        end
        // descending scan leaves the lowest valid index as the winner
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (r_slot_v[i]) begin
                w_any = 1'b1;
                w_pick = CW'(i);
                w_pick_t = r_slot_t[i];
            end
        end
        for (int i = 0; i < CHANNELS; i++) w_drain[i] = w_take && w_any && (w_pick == CW'(i));
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_press <= '0;
            r_release <= '0;
            r_long <= '0;
            r_slot_v <= '0;
            r_overflow <= '0;
            r_event_valid <= 1'b0;
            r_event_chan <= '0;
            r_event_type <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_deb[i] <= '0;
                r_hold[i] <= '0;
                r_slot_t[i] <= '0;
            end
        end else begin
            r_sync1 <= w_norm;
            r_sync2 <= r_sync1;
            r_press <= w_flip & ~r_level;
            r_release <= w_flip & r_level;
            r_level <= r_level ^ w_flip;
            for (int i = 0; i < CHANNELS; i++) begin
                r_deb[i] <= (r_sync2[i] != r_level[i] && !w_flip[i]) ? r_deb[i] + DW'(1) : '0;
                if (!r_level[i] || w_flip[i]) begin
                    r_hold[i] <= '0;
                    r_long[i] <= 1'b0;
                end else if (w_hit[i]) begin
                    r_hold[i] <= '0;
                    r_long[i] <= 1'b1;
                end else if (!r_long[i] || REPEAT_CYCLES > 0) begin
                    r_hold[i] <= r_hold[i] + HW'(1);
                end
                // a slot being drained this edge can accept the new event
                if (w_ev[i] && (!r_slot_v[i] || w_drain[i])) begin
                    r_slot_v[i] <= 1'b1;
                    r_slot_t[i] <= w_ev_t[i];
                end else begin
                    if (w_ev[i]) r_overflow[i] <= 1'b1;
                    if (w_drain[i]) r_slot_v[i] <= 1'b0;
                end
            end
            if (w_take) begin
                r_event_valid <= w_any;
                if (w_any) begin
                    r_event_chan <= w_pick;
                    r_event_type <= w_pick_t;
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;
    assign o_release = r_release;
    assign o_event_valid = r_event_valid;
    assign o_event_chan = r_event_chan;
    assign o_event_type = r_event_type;
    assign o_overflow = r_overflow;
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel input conditioner for active-low push buttons and keypad lines. Each channel gets synchronisation, debounce, press/release edge pulses, long-press detection and auto-repeat. All events are merged into a single valid/ready event stream for the controller. It replaces the single-button debounce plus edge-to-reset-pulse logic at the top level and serves the calculator keypad and reset button alike.

## Interface
- CHANNELS, 8: number of independent input channels (1..32).
- ACTIVE_LOW, 1: 1 = input level 0 means pressed; 0 = input level 1 means pressed.
- DEBOUNCE_CYCLES, 500000: consecutive cycles of a new synchronised level required before accepting it (≥1).
- LONG_CYCLES, 50000000: cycles of continuous debounced press before a long event (≥1).
- REPEAT_CYCLES, 10000000: period of repeat events after long; 0 disables repeat.
- clock  input  1  system clock (50 MHz).
- reset_n  input  1  reset; one clock; reset is synchronous and active-low.
- in  input  CHANNELS  raw asynchronous button/keypad lines.
- level  output  CHANNELS  debounced state, 1 = pressed.
- press  output  CHANNELS  one-cycle pulse on debounced 0→1.
- release  output  CHANNELS  one-cycle pulse on debounced 1→0.
- event_valid  output  1  event register holds an event.
- event_chan  output  $clog2(CHANNELS) (min 1)  channel of presented event.
- event_type  output  2  0 press, 1 release, 2 long, 3 repeat.
- event_ready  input  1  consumer accepts event when high with event_valid.
- overflow  output  CHANNELS  sticky: an event was dropped on this channel.

## Operation
- Reset (reset_n low at an edge): sync regs, level, counters, slots, event register, press, release and overflow all load the released state (0); event_chan/event_type = 0.
- Sync: two flops per channel. The input is normalised by ACTIVE_LOW so that 1 = pressed.
- Debounce: per-channel counter. It increments each cycle the synchronised value ≠ level and clears on any cycle they are equal. When the increment reaches DEBOUNCE_CYCLES, level flips, the counter clears, and press or release pulses on that same edge.
- Hold counter: clears on the press edge and increments while level = 1.
  - At LONG_CYCLES held cycles it fires a long event, then reloads.
  - If REPEAT_CYCLES > 0, a repeat event fires every REPEAT_CYCLES held cycles thereafter.
  - Release stops it; no long/repeat fires on the release edge.
- Pending slots: one slot per channel (valid + type). The edge that generates an event writes the slot.
  - If the slot is already valid and is not being drained that cycle, the new event is dropped and overflow[i] sets. It clears only on reset.
- Arbiter: when !event_valid or (event_valid and event_ready), the event register loads the lowest-index valid slot and clears that slot on the same edge. If no slot is valid, event_valid drops to 0.
- A slot drained into the event register on the same edge a new event arrives for that channel takes the new event; there is no overflow.
- Event outputs are stable while event_valid and !event_ready.

## Timing
- Input steady pressed from before edge 1: level/press assert at edge DEBOUNCE_CYCLES+2. The slot is written on the same edge; event_valid is high after edge DEBOUNCE_CYCLES+3.
- Glitch shorter than DEBOUNCE_CYCLES cycles (post-sync): no level change and no events.
- Long event fires on edge LONG_CYCLES after the press edge. Repeats fire at +REPEAT_CYCLES intervals after that.
- Throughput: one event per cycle with event_ready tied high.
- Button held through reset: after reset_n rises, a normal press is generated after the debounce latency.
- reset_n low mid-debounce or mid-hold: everything is discarded; there is no release event.

## Test plan
Bench parameters: CHANNELS=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1, event_ready=1 unless stated.
- in[1] driven 1→0 and held → level[1]=1 and press[1] one cycle at edge 6; event (chan 1, type 0) valid after edge 7, for one cycle.
- in[0] bounces 0/1 every 2 cycles for 30 cycles, then settles at 1 → no level change and no events.
- in[2] held 40 cycles past its press edge → long at press+20, repeats at press+28 and press+36. Release → release event (type 1); no further repeats.
- in[0] and in[3] pressed on the same cycle → chan 0 presented first, chan 3 on the next cycle. Holding event_ready=0 keeps chan 0 stable for 5 cycles.
- event_ready=0; press then release ch1 → press presented and ch1 slot holds release. A second press after debounce → overflow[1]=1; the dropped press is never emitted.
- reset_n=0 for 1 cycle while ch2 is held mid-long → all outputs 0 next cycle. A fresh press event follows 6 edges after reset_n rises.
